// File: rtl/lu_pkg.sv
// Shared types for the lu matrix store: complex element layout and the
// per-bank life-cycle state.
package lu_pkg;

   localparam int WIDTH_DEF = 64;

   // Element layout {imag, real}; "real" is a keyword, hence "re".
   typedef struct packed {
      logic [WIDTH_DEF-1:0] imag;
      logic [WIDTH_DEF-1:0] re;
   } cplx_t;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      LOADING = 2'd1,
      FULL    = 2'd2,
      ACTIVE  = 2'd3
   } bank_state_e;

endpackage

// File: rtl/lu_row_ram.sv
// One matrix bank: SIZE rows of ROW_W bits, 1 read + 1 write port,
// read-before-write, RD_LAT-deep registered read data.
module lu_row_ram #(
   parameter int SIZE   = 16,
   parameter int ROW_W  = 2048,
   parameter int RD_LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we,
   input  logic [$clog2(SIZE)-1:0] waddr,
   input  logic [ROW_W-1:0]        wdata,
   input  logic [$clog2(SIZE)-1:0] raddr,
   output logic [ROW_W-1:0]        rdata
);

   logic [ROW_W-1:0] mem    [SIZE];
   logic [ROW_W-1:0] pipe_q [RD_LAT];

   // Row write port.
   // NOTE: the storage array is deliberately not reset; bank state in the
   // top decides whether its contents mean anything.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read pipeline; the non-blocking read of mem sees the pre-write row.
   // NOTE: non-blocking assignments here give read-before-write and
   // race-free register-to-register transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= mem[raddr];
         for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign rdata = pipe_q[RD_LAT-1];

endmodule

// File: rtl/lu_mat_store.sv
// Double-buffered complex-matrix row store for the lu engine. The host
// fills one bank in raster order while the engine works on the other.
// Optional feature macro: LU_ROW_PERMUTE_EN (logical->physical row map
// on the ACTIVE bank, driven by swap_i / swap_a_i / swap_b_i).
module lu_mat_store
   import lu_pkg::*;
#(
   parameter int SIZE   = 16,
   parameter int WIDTH  = WIDTH_DEF,
   parameter int RD_LAT = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [2*WIDTH-1:0]        host_elem_i,
   input  logic                      host_elem_valid_i,
   output logic                      host_elem_ready_o,
   input  logic [$clog2(SIZE)-1:0]   mat_row_read_addr_i,
   input  logic                      mat_row_read_addr_valid_i,
   output logic [SIZE*2*WIDTH-1:0]   mat_row_o,
   output logic                      mat_row_valid_o,
   output logic [$clog2(SIZE)-1:0]   mat_row_addr_o,
   input  logic [SIZE*2*WIDTH-1:0]   mat_row_i,
   input  logic                      mat_row_valid_i,
   input  logic [$clog2(SIZE)-1:0]   mat_row_write_addr_i,
   output logic                      mat_row_ready_o,
   output logic                      start_o,
   input  logic                      done_i,
   output logic                      busy_o,
   output logic                      load_bank_o
`ifdef LU_ROW_PERMUTE_EN
   ,
   input  logic                      swap_i,
   input  logic [$clog2(SIZE)-1:0]   swap_a_i,
   input  logic [$clog2(SIZE)-1:0]   swap_b_i
`endif
);

   localparam int AW    = $clog2(SIZE);
   localparam int EW    = 2 * WIDTH;
   localparam int ROW_W = SIZE * EW;
   localparam logic [AW-1:0] LAST = AW'(SIZE - 1);

   bank_state_e      state_q [2];
   bank_state_e      state_n [2];
   logic             load_bank_q, load_bank_n;
   logic             active_bank_q;
   logic             busy_q, busy_n;
   logic             start_q, start_n;
   logic             start_bank_q, start_bank_n;
   logic             ready_q, ready_n;
   logic [AW-1:0]    row_cnt_q, col_cnt_q;
   logic [ROW_W-1:0] stage_q, host_row;
   logic             vld_q  [RD_LAT];
   logic [AW-1:0]    addr_q [RD_LAT];
   logic             bank_q [RD_LAT];

   logic             we    [2];
   logic [AW-1:0]    waddr [2];
   logic [ROW_W-1:0] wdata [2];
   logic [ROW_W-1:0] rdata [2];
   logic [AW-1:0]    phys_rd, phys_wr;

   logic host_acc, host_commit, host_last, done_acc, rd_acc, wr_acc;
   logic any_active_n;

   assign host_acc    = host_elem_valid_i & ready_q;
   assign host_commit = host_acc & (col_cnt_q == LAST);
   assign host_last   = host_commit & (row_cnt_q == LAST);
   assign done_acc    = done_i & busy_q;
   assign rd_acc      = mat_row_read_addr_valid_i & busy_q;
   assign wr_acc      = mat_row_valid_i & busy_q;

`ifdef LU_ROW_PERMUTE_EN
   logic [AW-1:0] map_q [SIZE];

   // Row map: identity after reset and at every start, swapped on request.
   always_ff @(posedge clk_i) begin
      if (rst_i || start_q) begin
         for (int i = 0; i < SIZE; i++) map_q[i] <= AW'(i);
      end else if (swap_i && busy_q) begin
         map_q[swap_a_i] <= map_q[swap_b_i];
         map_q[swap_b_i] <= map_q[swap_a_i];
      end
   end

   assign phys_rd = map_q[mat_row_read_addr_i];
   assign phys_wr = map_q[mat_row_write_addr_i];
`else
   assign phys_rd = mat_row_read_addr_i;
   assign phys_wr = mat_row_write_addr_i;
`endif

   // Next bank states plus the outputs derived from them.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_n[0] = state_q[0];
      state_n[1] = state_q[1];
      if (start_q)  state_n[start_bank_q]  = ACTIVE;
      if (done_acc) state_n[active_bank_q] = EMPTY;
      if (host_acc) state_n[load_bank_q]   = host_last ? FULL : LOADING;

      load_bank_n = load_bank_q;
      if (state_n[load_bank_q] == FULL && state_n[~load_bank_q] == EMPTY)
         load_bank_n = ~load_bank_q;

      any_active_n = (state_n[0] == ACTIVE) || (state_n[1] == ACTIVE);
      busy_n       = any_active_n;
      start_n      = !any_active_n && (state_n[0] == FULL || state_n[1] == FULL);
      start_bank_n = (state_n[0] == FULL) ? 1'b0 : 1'b1;
      ready_n      = (state_n[load_bank_n] == EMPTY) || (state_n[load_bank_n] == LOADING);
   end

   // Bank control registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q[0]    <= EMPTY;
         state_q[1]    <= EMPTY;
         load_bank_q   <= 1'b0;
         active_bank_q <= 1'b0;
         busy_q        <= 1'b0;
         start_q       <= 1'b0;
         start_bank_q  <= 1'b0;
         ready_q       <= 1'b0;
      end else begin
         state_q[0]    <= state_n[0];
         state_q[1]    <= state_n[1];
         load_bank_q   <= load_bank_n;
         busy_q        <= busy_n;
         start_q       <= start_n;
         start_bank_q  <= start_bank_n;
         ready_q       <= ready_n;
         if (start_q) active_bank_q <= start_bank_q;
      end
   end

   // Raster position of the next host element.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         row_cnt_q <= '0;
         col_cnt_q <= '0;
      end else if (host_acc) begin
         col_cnt_q <= (col_cnt_q == LAST) ? '0 : col_cnt_q + 1'b1;
         if (col_cnt_q == LAST) row_cnt_q <= (row_cnt_q == LAST) ? '0 : row_cnt_q + 1'b1;
      end
   end

   // Staging row; stale columns are harmless because the counters restart.
   always_ff @(posedge clk_i) begin
      if (host_acc) stage_q[int'(col_cnt_q)*EW +: EW] <= host_elem_i;
   end

   // Completed host row: staged columns plus the beat being accepted.
   always_comb begin
      host_row = stage_q;
      host_row[(SIZE-1)*EW +: EW] = host_elem_i;
   end

   // Write-port steering: host row commits to the load bank, engine
   // writebacks to the ACTIVE bank; the two are never the same bank.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         if (host_commit && load_bank_q == 1'(b)) begin
            we[b]    = 1'b1;
            waddr[b] = row_cnt_q;
            wdata[b] = host_row;
         end else begin
            we[b]    = wr_acc && (active_bank_q == 1'(b));
            waddr[b] = phys_wr;
            wdata[b] = mat_row_i;
         end
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      lu_row_ram #(
         .SIZE   (SIZE),
         .ROW_W  (ROW_W),
         .RD_LAT (RD_LAT)
      ) u_ram (
         .clk   (clk_i),
         .rst   (rst_i),
         .we    (we[b]),
         .waddr (waddr[b]),
         .wdata (wdata[b]),
         .raddr (phys_rd),
         .rdata (rdata[b])
      );
   end

   // Read-response tracking aligned with the RAM read pipeline.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < RD_LAT; i++) begin
            vld_q[i]  <= 1'b0;
            addr_q[i] <= '0;
            bank_q[i] <= 1'b0;
         end
      end else begin
         vld_q[0]  <= rd_acc;
         addr_q[0] <= mat_row_read_addr_i;
         bank_q[0] <= active_bank_q;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i]  <= vld_q[i-1];
            addr_q[i] <= addr_q[i-1];
            bank_q[i] <= bank_q[i-1];
         end
      end
   end

   assign mat_row_valid_o   = vld_q[RD_LAT-1];
   assign mat_row_addr_o    = addr_q[RD_LAT-1];
   assign mat_row_o         = vld_q[RD_LAT-1] ? rdata[bank_q[RD_LAT-1]] : '0;
   assign host_elem_ready_o = ready_q;
   assign mat_row_ready_o   = busy_q;
   assign start_o           = start_q;
   assign busy_o            = busy_q;
   assign load_bank_o       = load_bank_q;

endmodule

// File: tb/tb_lu_mat_store.sv
// Self-checking bench for lu_mat_store: directed scenarios with a read
// scoreboard; a monitor pops the expected row on every mat_row_valid_o.
module tb_lu_mat_store;

   localparam int SIZE   = 16;
   localparam int WIDTH  = 64;
   localparam int RD_LAT = 1;
   localparam int AW     = $clog2(SIZE);
   localparam int EW     = 2 * WIDTH;
   localparam int ROW_W  = SIZE * EW;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [EW-1:0]    host_elem = '0;
   logic             host_valid = 1'b0;
   logic             host_elem_ready_o;
   logic [AW-1:0]    rd_addr = '0;
   logic             rd_valid = 1'b0;
   logic [ROW_W-1:0] mat_row_o;
   logic             mat_row_valid_o;
   logic [AW-1:0]    mat_row_addr_o;
   logic [ROW_W-1:0] wr_row = '0;
   logic             wr_valid = 1'b0;
   logic [AW-1:0]    wr_addr = '0;
   logic             mat_row_ready_o;
   logic             start_o;
   logic             done = 1'b0;
   logic             busy_o;
   logic             load_bank_o;
`ifdef LU_ROW_PERMUTE_EN
   logic             swap = 1'b0;
   logic [AW-1:0]    swap_a = '0;
   logic [AW-1:0]    swap_b = '0;
`endif

   always #5 clk = ~clk;

   lu_mat_store #(.SIZE(SIZE), .WIDTH(WIDTH), .RD_LAT(RD_LAT)) dut (
      .clk_i                     (clk),
      .rst_i                     (rst),
      .host_elem_i               (host_elem),
      .host_elem_valid_i         (host_valid),
      .host_elem_ready_o         (host_elem_ready_o),
      .mat_row_read_addr_i       (rd_addr),
      .mat_row_read_addr_valid_i (rd_valid),
      .mat_row_o                 (mat_row_o),
      .mat_row_valid_o           (mat_row_valid_o),
      .mat_row_addr_o            (mat_row_addr_o),
      .mat_row_i                 (wr_row),
      .mat_row_valid_i           (wr_valid),
      .mat_row_write_addr_i      (wr_addr),
      .mat_row_ready_o           (mat_row_ready_o),
      .start_o                   (start_o),
      .done_i                    (done),
      .busy_o                    (busy_o),
      .load_bank_o               (load_bank_o)
`ifdef LU_ROW_PERMUTE_EN
      ,
      .swap_i                    (swap),
      .swap_a_i                  (swap_a),
      .swap_b_i                  (swap_b)
`endif
   );

   typedef struct {
      logic [ROW_W-1:0] row;
      logic [AW-1:0]    addr;
      int               due;
   } rd_exp_t;

   rd_exp_t          sbq [$];
   rd_exp_t          mon_e;
   logic [ROW_W-1:0] model [SIZE];   // expected ACTIVE-bank contents by logical row
   logic [ROW_W-1:0] last_row = '0;
   int               n_vec = 0;
   int               n_err = 0;
   int               cyc = 0;
   bit               early;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [EW-1:0] elem(input int base, input int r, input int c);
      logic [WIDTH-1:0] re;
      re = WIDTH'(base + SIZE * r + c);
      return {~re, re};
   endfunction

   function automatic logic [ROW_W-1:0] mk_row(input int base, input int r);
      logic [ROW_W-1:0] row;
      for (int c = 0; c < SIZE; c++) row[c*EW +: EW] = elem(base, r, c);
      return row;
   endfunction

   task automatic set_model(input int base);
      for (int r = 0; r < SIZE; r++) model[r] = mk_row(base, r);
   endtask

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic cmp_row(input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp, input int a);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         for (int j = 0; j < SIZE; j++) begin
            if (got[j*EW +: EW] !== exp[j*EW +: EW]) begin
               $display("FAIL rd_row%0d elem %0d: got %h expected %h", a, j,
                        got[j*EW +: EW], exp[j*EW +: EW]);
               break;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one read this cycle; push the expected response when it is legal.
   task automatic rd(input int r, input bit expect_resp, input logic [ROW_W-1:0] exp_row);
      rd_addr  = AW'(r);
      rd_valid = 1'b1;
      if (expect_resp) sbq.push_back('{row: exp_row, addr: AW'(r), due: cyc + RD_LAT});
      tick();
      rd_valid = 1'b0;
   endtask

   // Stream count elements of pattern base in raster order.
   task automatic load_matrix(input int base, input int count, input bit done_on_last);
      int waited;
      early = 1'b0;
      for (int k = 0; k < count; k++) begin
         host_elem  = elem(base, k / SIZE, k % SIZE);
         host_valid = 1'b1;
         waited = 0;
         while (!host_elem_ready_o && waited < 200) begin
            if (start_o) early = 1'b1;
            tick();
            waited++;
         end
         if (!host_elem_ready_o) begin
            n_vec++;
            n_err++;
            $display("FAIL load_timeout: ready 0 at element %0d, required 1", k);
            break;
         end
         if (start_o) early = 1'b1;
         if (done_on_last && k == count - 1) done = 1'b1;
         tick();
         done = 1'b0;
      end
      host_valid = 1'b0;
   endtask

   // Monitor: every valid row must match the oldest outstanding expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (mat_row_valid_o) begin
            if (sbq.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL rd_unexpected: valid for row %0d, required no response", mat_row_addr_o);
            end else begin
               mon_e = sbq.pop_front();
               cmp_row(mat_row_o, mon_e.row, int'(mon_e.addr));
               check("rd_addr", 128'(mat_row_addr_o), 128'(mon_e.addr));
               check("rd_latency", 128'(cyc), 128'(mon_e.due));
               last_row = mat_row_o;
            end
         end
      end
   end

   initial begin
      logic [EW-1:0] e53;
      int waited;

      // Reset state.
      repeat (3) tick();
      check("rst_ready", 128'(host_elem_ready_o), 128'd0);
      check("rst_start", 128'(start_o), 128'd0);
      check("rst_busy", 128'(busy_o), 128'd0);
      check("rst_valid", 128'(mat_row_valid_o), 128'd0);
      check("rst_load_bank", 128'(load_bank_o), 128'd0);
      check("rst_row_ready", 128'(mat_row_ready_o), 128'd0);
      check("rst_row_data", 128'(|mat_row_o), 128'd0);
      rst = 1'b0;
      tick();
      check("ready_after_rst", 128'(host_elem_ready_o), 128'd1);

      // Read while idle is dropped (monitor flags any response).
      rd(0, 1'b0, '0);

      // Full load of bank0, start exactly one cycle after last accept.
      load_matrix(0, SIZE * SIZE, 1'b0);
      check("load0_no_early_start", 128'(early), 128'd0);
      check("load0_start", 128'(start_o), 128'd1);
      check("load0_busy_pre", 128'(busy_o), 128'd0);
      tick();
      check("load0_busy", 128'(busy_o), 128'd1);
      check("load0_start_pulse", 128'(start_o), 128'd0);
      check("load0_load_bank", 128'(load_bank_o), 128'd1);
      set_model(0);

      // Row 3, element 5 = {~53, 53}.
      rd(3, 1'b1, model[3]);
      tick();
      e53 = {~64'd53, 64'd53};
      check("row3_elem5", 128'(last_row[5*EW +: EW]), 128'(e53));

      // Write/read hazard on row 2.
      check("wr_ready", 128'(mat_row_ready_o), 128'd1);
      wr_row   = '1;
      wr_addr  = AW'(2);
      wr_valid = 1'b1;
      rd(2, 1'b1, model[2]);
      wr_valid = 1'b0;
      model[2] = '1;
      rd(2, 1'b1, model[2]);

      // Backpressure: bank1 loads FULL while bank0 is ACTIVE.
      load_matrix(1000, SIZE * SIZE, 1'b0);
      check("bp_ready_low", 128'(host_elem_ready_o), 128'd0);
      check("bp_no_start", 128'(start_o), 128'd0);
      check("bp_load_bank", 128'(load_bank_o), 128'd1);
      tick();
      tick();
      check("bp_ready_hold", 128'(host_elem_ready_o), 128'd0);
      done = 1'b1;
      rd(1, 1'b1, model[1]);            // in flight across done
      done = 1'b0;
      check("bp_busy_after_done", 128'(busy_o), 128'd0);
      check("bp_start_after_done", 128'(start_o), 128'd1);
      check("bp_ready_after_done", 128'(host_elem_ready_o), 128'd1);
      check("bp_load_bank_back", 128'(load_bank_o), 128'd0);
      done = 1'b1;                      // ignored while busy_o=0
      tick();
      done = 1'b0;
      check("bp_busy_bank1", 128'(busy_o), 128'd1);
      check("bp_start_once", 128'(start_o), 128'd0);
      set_model(1000);
      rd(7, 1'b1, model[7]);

      // Coincidence: last bank0 element with done for bank1.
      load_matrix(2000, SIZE * SIZE, 1'b1);
      check("co_busy_low", 128'(busy_o), 128'd0);
      check("co_start", 128'(start_o), 128'd1);
      check("co_load_bank", 128'(load_bank_o), 128'd1);
      check("co_ready", 128'(host_elem_ready_o), 128'd1);
      tick();
      check("co_busy_high", 128'(busy_o), 128'd1);
      check("co_start_once", 128'(start_o), 128'd0);
      set_model(2000);
      rd(15, 1'b1, model[15]);

      // Reset at element 100, with a read in the reset cycle.
      load_matrix(5000, 100, 1'b0);
      rst = 1'b1;
      rd(4, 1'b0, '0);
      tick();
      rst = 1'b0;
      tick();
      check("mid_rst_busy", 128'(busy_o), 128'd0);
      check("mid_rst_load_bank", 128'(load_bank_o), 128'd0);
      check("mid_rst_ready", 128'(host_elem_ready_o), 128'd1);
      load_matrix(3000, SIZE * SIZE, 1'b0);
      check("reload_no_early_start", 128'(early), 128'd0);
      check("reload_start", 128'(start_o), 128'd1);
      tick();
      check("reload_busy", 128'(busy_o), 128'd1);
      set_model(3000);
      rd(0, 1'b1, model[0]);
      rd(1, 1'b1, model[1]);
      rd(15, 1'b1, model[15]);

`ifdef LU_ROW_PERMUTE_EN
      // Swap 0<->5: same-cycle read sees old map, next read sees new map.
      swap   = 1'b1;
      swap_a = AW'(0);
      swap_b = AW'(5);
      rd(0, 1'b1, model[0]);
      swap = 1'b0;
      rd(0, 1'b1, model[5]);
      rd(5, 1'b1, model[0]);
      swap   = 1'b1;
      swap_a = AW'(3);
      swap_b = AW'(3);
      tick();
      swap = 1'b0;
      rd(3, 1'b1, model[3]);
`endif

      // Release the bank and drain the scoreboard.
      done = 1'b1;
      tick();
      done = 1'b0;
      check("final_busy", 128'(busy_o), 128'd0);
      waited = 0;
      while (sbq.size() != 0 && waited < 20) begin
         tick();
         waited++;
      end
      check("sb_drain", 128'(sbq.size()), 128'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
